// File: rtl/ctrl_seq_pkg.sv
// Shared encodings for the accumulator MCU sequencer: instruction classes,
// addressing modes, ALU operation codes, PSR flag index and FSM states.
package ctrl_seq_pkg;

  localparam int INST_WIDTH = 8;
  localparam int PSR_WIDTH  = 4;
  localparam int PSR_Z      = 0;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_JZ    = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_IMM  = 2'b01;
  localparam logic [1:0] MODE_DIR  = 2'b10;
  localparam logic [1:0] MODE_IND  = 2'b11;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_XOR  = 3'd5;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_DISPATCH  = 3'd2,
    S_FETCH_IMM = 3'd3,
    S_IMM_WAIT  = 3'd4,
    S_MEM_RD    = 3'd5,
    S_EXEC      = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  // Only accumulator-writing classes map to a real ALU function.
  function automatic logic [2:0] class_alu_op(input logic [3:0] cls);
    logic [2:0] op;
    op = ALU_PASS;
    case (cls)
      OP_ADD:  op = ALU_ADD;
      OP_SUB:  op = ALU_SUB;
      OP_AND:  op = ALU_AND;
      OP_OR:   op = ALU_OR;
      OP_XOR:  op = ALU_XOR;
      default: op = ALU_PASS;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ctrl_seq_decode.sv
// Combinational instruction decoder: classifies the latched opcode into the
// control properties the sequencer FSM branches on.
module ctrl_decode
  import ctrl_seq_pkg::*;
(
  input  logic [INST_WIDTH-1:0] opcode,
  output logic                  needs_operand,
  output logic                  needs_mem,
  output logic                  is_store,
  output logic                  is_jump,
  output logic                  is_cond,
  output logic                  is_halt,
  output logic                  is_illegal,
  output logic                  writes_acc,
  output logic                  mem_indirect,
  output logic [2:0]            alu_op
);

  logic [3:0] cls;
  logic [1:0] mode;
  logic       addr_word;
  logic       unused_low_bits;

  assign cls             = opcode[7:4];
  assign mode            = opcode[3:2];
  assign unused_low_bits = ^opcode[1:0];

  always_comb begin
    is_store   = 1'b0;
    is_jump    = 1'b0;
    is_cond    = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    writes_acc = 1'b0;
    case (cls)
      OP_NOP: ;
      OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
        writes_acc = 1'b1;
      OP_STORE: begin
        // Storing to an immediate has no meaning; it degrades to illegal.
        is_store   = (mode != MODE_IMM);
        is_illegal = (mode == MODE_IMM);
      end
      OP_JMP:
        is_jump = 1'b1;
      OP_JZ: begin
        is_jump = 1'b1;
        is_cond = 1'b1;
      end
      OP_HALT:
        is_halt = 1'b1;
      default:
        is_illegal = 1'b1;
    endcase
  end

  assign addr_word     = (mode == MODE_IMM) || (mode == MODE_DIR);
  assign needs_operand = is_jump || ((writes_acc || is_store) && addr_word);
  assign needs_mem     = writes_acc && ((mode == MODE_DIR) || (mode == MODE_IND));
  assign mem_indirect  = (writes_acc || is_store) && (mode == MODE_IND);
  assign alu_op        = writes_acc ? class_alu_op(cls) : ALU_PASS;

endmodule

// File: rtl/ctrl_seq.sv
// Instruction sequencer and program counter for the accumulator MCU.
// Optional feature macro CTRL_TRAP_ILLEGAL_EN: illegal opcodes halt the core and raise `illegal`.
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int PC_WIDTH    = 8,
  parameter int DMEM_RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INST_WIDTH-1:0] opcode,
  input  logic [PSR_WIDTH-1:0]  psr,
  input  logic [INST_WIDTH-1:0] imm,
  output logic [PC_WIDTH-1:0]   imem_addr,
  output logic                  imem_rd,
  output logic                  opcode_update,
  output logic                  imm_update,
  output logic                  psr_update,
  output logic                  acc_update,
  output logic [2:0]            alu_op,
  output logic                  opb_sel,
  output logic                  dmem_re,
  output logic                  dmem_we,
  output logic                  dmem_addr_sel,
  output logic                  halted
`ifdef CTRL_TRAP_ILLEGAL_EN
  ,
  output logic                  illegal
`endif
);

`ifdef CTRL_TRAP_ILLEGAL_EN
  localparam bit TRAP_ILLEGAL = 1'b1;
`else
  localparam bit TRAP_ILLEGAL = 1'b0;
`endif
  localparam logic [1:0] RD_LAST = 2'(DMEM_RD_LAT - 1);

  state_t                state_q;
  state_t                state_d;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [1:0]            rd_cnt_q;
  logic                  rd_last;
  logic                  in_instr;
  logic                  take_jump;
  logic [PC_WIDTH-1:0]   jump_target;
  logic                  unused_psr;

  logic       needs_operand;
  logic       needs_mem;
  logic       is_store;
  logic       is_jump;
  logic       is_cond;
  logic       is_halt;
  logic       is_illegal;
  logic       writes_acc;
  logic       mem_indirect;
  logic [2:0] dec_alu_op;

  ctrl_decode u_decode (
    .opcode        (opcode),
    .needs_operand (needs_operand),
    .needs_mem     (needs_mem),
    .is_store      (is_store),
    .is_jump       (is_jump),
    .is_cond       (is_cond),
    .is_halt       (is_halt),
    .is_illegal    (is_illegal),
    .writes_acc    (writes_acc),
    .mem_indirect  (mem_indirect),
    .alu_op        (dec_alu_op)
  );

  assign unused_psr  = ^psr;
  assign rd_last     = (rd_cnt_q == RD_LAST);
  assign take_jump   = is_jump && (!is_cond || psr[PSR_Z]);
  assign jump_target = PC_WIDTH'(imm);

  // The opcode is stable from DISPATCH onward, so decode-derived selects hold until EXEC.
  assign in_instr = (state_q == S_DISPATCH) || (state_q == S_FETCH_IMM) ||
                    (state_q == S_IMM_WAIT) || (state_q == S_MEM_RD) ||
                    (state_q == S_EXEC);

  assign imem_addr     = pc_q;
  assign alu_op        = (in_instr && !rst) ? dec_alu_op : ALU_PASS;
  assign dmem_addr_sel = in_instr && !rst && mem_indirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      rd_cnt_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= (state_q == S_MEM_RD && !rd_last) ? rd_cnt_q + 2'd1 : 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
    end else if (state_q == S_FETCH || state_q == S_FETCH_IMM) begin
      pc_q <= pc_q + PC_WIDTH'(1);
    end else if (state_q == S_EXEC && take_jump) begin
      pc_q <= jump_target;
    end
  end

`ifdef CTRL_TRAP_ILLEGAL_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (state_q == S_DISPATCH && is_illegal) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q && !rst;
`endif

  always_comb begin
    state_d       = state_q;
    imem_rd       = 1'b0;
    opcode_update = 1'b0;
    imm_update    = 1'b0;
    psr_update    = 1'b0;
    acc_update    = 1'b0;
    opb_sel       = 1'b0;
    dmem_re       = 1'b0;
    dmem_we       = 1'b0;
    halted        = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_rd = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        opcode_update = 1'b1;
        state_d       = S_DISPATCH;
      end
      S_DISPATCH: begin
        if (is_illegal) begin
          state_d = TRAP_ILLEGAL ? S_HALT : S_EXEC;
        end else if (is_halt) begin
          state_d = S_HALT;
        end else if (needs_operand) begin
          state_d = S_FETCH_IMM;
        end else if (needs_mem) begin
          state_d = S_MEM_RD;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_FETCH_IMM: begin
        imem_rd = 1'b1;
        state_d = S_IMM_WAIT;
      end
      S_IMM_WAIT: begin
        imm_update = 1'b1;
        state_d    = needs_mem ? S_MEM_RD : S_EXEC;
      end
      S_MEM_RD: begin
        dmem_re = (rd_cnt_q == 2'd0);
        if (rd_last) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // NOP and untrapped illegal opcodes pass through here with no strobes.
        acc_update = writes_acc;
        psr_update = writes_acc;
        opb_sel    = writes_acc && needs_mem;
        dmem_we    = is_store;
        state_d    = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    if (rst) begin
      imem_rd       = 1'b0;
      opcode_update = 1'b0;
      imm_update    = 1'b0;
      psr_update    = 1'b0;
      acc_update    = 1'b0;
      opb_sel       = 1'b0;
      dmem_re       = 1'b0;
      dmem_we       = 1'b0;
      halted        = 1'b0;
    end
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq: an instruction-level model predicts strobe events with cycle stamps.
module tb_ctrl_seq;
  import ctrl_seq_pkg::*;

  localparam int LAT = 1;
`ifdef CTRL_TRAP_ILLEGAL_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam int K_FETCH = 0;
  localparam int K_OPC   = 1;
  localparam int K_IMM   = 2;
  localparam int K_RD    = 3;
  localparam int K_WE    = 4;
  localparam int K_EXEC  = 5;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } ev_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [INST_WIDTH-1:0] opcode = '0;
  logic [PSR_WIDTH-1:0]  psr = '0;
  logic [INST_WIDTH-1:0] imm = '0;
  logic [7:0]            imem_addr;
  logic                  imem_rd, opcode_update, imm_update, psr_update, acc_update;
  logic [2:0]            alu_op;
  logic                  opb_sel, dmem_re, dmem_we, dmem_addr_sel, halted;
`ifdef CTRL_TRAP_ILLEGAL_EN
  logic                  illegal;
`endif

  logic [7:0] imem [256];
  logic [7:0] imem_data = '0;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  mon_en = 1'b0;
  bit  psr_z = 1'b0;
  int  halt_cyc;
  int  freeze_pc;
  bit  exp_ill;

  ctrl_seq #(.PC_WIDTH(8), .DMEM_RD_LAT(LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .psr           (psr),
    .imm           (imm),
    .imem_addr     (imem_addr),
    .imem_rd       (imem_rd),
    .opcode_update (opcode_update),
    .imm_update    (imm_update),
    .psr_update    (psr_update),
    .acc_update    (acc_update),
    .alu_op        (alu_op),
    .opb_sel       (opb_sel),
    .dmem_re       (dmem_re),
    .dmem_we       (dmem_we),
    .dmem_addr_sel (dmem_addr_sel),
    .halted        (halted)
`ifdef CTRL_TRAP_ILLEGAL_EN
    ,
    .illegal       (illegal)
`endif
  );

  always #5 clk = ~clk;

  // Environment: synchronous instruction memory and the register-bank latches.
  always @(posedge clk) begin
    if (imem_rd) imem_data <= imem[imem_addr];
    if (opcode_update) opcode <= imem_data;
    if (imm_update) imm <= imem_data;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic pop_cmp(input int kind, input int val);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL event unexpected kind=%0d val=%0d at cyc %0d, none expected", kind, val, cyc);
    end else begin
      e = q.pop_front();
      if (e.cyc != cyc || e.kind != kind || e.val != val) begin
        errors++;
        $display("FAIL event got cyc=%0d kind=%0d val=%0d want cyc=%0d kind=%0d val=%0d",
                 cyc, kind, val, e.cyc, e.kind, e.val);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (imem_rd) pop_cmp(K_FETCH, int'(imem_addr));
      if (opcode_update) pop_cmp(K_OPC, 0);
      if (imm_update) pop_cmp(K_IMM, 0);
      if (dmem_re) pop_cmp(K_RD, int'({alu_op, dmem_addr_sel}));
      if (dmem_we) pop_cmp(K_WE, int'(dmem_addr_sel));
      if (acc_update || psr_update)
        pop_cmp(K_EXEC, int'({alu_op, opb_sel, psr_update, acc_update}));
      chk("excl_opc_imm", int'(opcode_update && imm_update), 0);
      chk("excl_re_we", int'(dmem_re && dmem_we), 0);
      chk("halted", int'(halted), int'(cyc >= halt_cyc));
      if (cyc >= halt_cyc) chk("halt_pc", int'(imem_addr), freeze_pc);
`ifdef CTRL_TRAP_ILLEGAL_EN
      chk("illegal", int'(illegal), int'(exp_ill && cyc >= halt_cyc));
`endif
      cyc++;
    end
  end

  function automatic void push(input int c, input int k, input int v, input int lim);
    ev_t e;
    if (c < lim) begin
      e.cyc = c; e.kind = k; e.val = v;
      q.push_back(e);
    end
  endfunction

  // Instruction-level interpreter: walks the program and stamps each strobe
  // with the cycle implied by the documented per-instruction latencies.
  function automatic void model(input int lim);
    int t, pc, c, cls, mode, alu;
    bit bad, mem;
    t = 0; pc = 0;
    halt_cyc = 1 << 30; freeze_pc = 0; exp_ill = 1'b0;
    while (t < lim) begin
      cls  = int'(imem[pc][7:4]);
      mode = int'(imem[pc][3:2]);
      push(t, K_FETCH, pc, lim);
      push(t + 1, K_OPC, 0, lim);
      pc = (pc + 1) % 256;
      bad = !(cls <= 9 || cls == 15) || (cls == 2 && mode == 1);
      if ((bad && TRAP) || (!bad && cls == 15)) begin
        halt_cyc = t + 3; freeze_pc = pc; exp_ill = bad;
        break;
      end
      if (bad || cls == 0) begin
        t += 4;
        continue;
      end
      c = t + 3;
      if (cls == 8 || cls == 9) begin
        push(c, K_FETCH, pc, lim);
        push(c + 1, K_IMM, 0, lim);
        if (cls == 8 || psr_z) pc = int'(imem[pc]);
        else pc = (pc + 1) % 256;
        t = t + 6;
        continue;
      end
      if (mode == 1 || mode == 2) begin
        push(c, K_FETCH, pc, lim);
        push(c + 1, K_IMM, 0, lim);
        pc = (pc + 1) % 256;
        c += 2;
      end
      if (cls == 2) begin
        push(c, K_WE, int'(mode == 3), lim);
        t = c + 1;
        continue;
      end
      alu = (cls == 1) ? 0 : cls - 2;
      mem = (mode >= 2);
      if (mem) begin
        push(c, K_RD, alu * 2 + int'(mode == 3), lim);
        c += LAT;
      end
      push(c, K_EXEC, alu * 8 + int'(mem) * 4 + 3, lim);
      t = c + 1;
    end
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_phase(input int n);
    psr = '0;
    psr[PSR_Z] = psr_z;
    q.delete();
    model(n);
    mon_en = 1'b0;
    do_reset();
    cyc = 0;
    mon_en = 1'b1;
    repeat (n) @(posedge clk);
    #1 mon_en = 1'b0;
    chk("drain", q.size(), 0);
  endtask

  task automatic reset_test();
    int strobes;
    clear_mem();
    imem[0] = 8'h38; imem[1] = 8'h10;
    psr = '0;
    mon_en = 1'b0;
    do_reset();
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_acc", int'(acc_update), 1);
    chk("pre_rst_alu", int'(alu_op), 1);
    rst = 1'b1;
    #1;
    repeat (4) begin
      strobes = int'({imem_rd, opcode_update, imm_update, psr_update, acc_update,
                      dmem_re, dmem_we, opb_sel, dmem_addr_sel, alu_op, halted});
      chk("rst_strobes", strobes, 0);
      @(posedge clk);
      @(negedge clk);
    end
    chk("rst_pc", int'(imem_addr), 0);
    rst = 1'b0;
    #1;
    chk("rel_imem_rd", int'(imem_rd), 1);
    chk("rel_addr", int'(imem_addr), 0);
    @(posedge clk);
    @(negedge clk);
    chk("rel_decode", int'(opcode_update), 1);
  endtask

  initial begin
    int cls;
    reset_test();

    clear_mem(); imem[0] = 8'h14; imem[1] = 8'h05; psr_z = 0; run_phase(14);
    clear_mem(); imem[0] = 8'h38; imem[1] = 8'h10; run_phase(16);
    clear_mem(); imem[0] = 8'h2C; run_phase(12);
    clear_mem(); imem[0] = 8'h90; imem[1] = 8'h40; psr_z = 0; run_phase(14);
    psr_z = 1; run_phase(14);
    clear_mem(); imem[0] = 8'h80; imem[1] = 8'hFE; imem[8'hFE] = 8'h80; imem[8'hFF] = 8'h00;
    psr_z = 0; run_phase(30);
    clear_mem(); imem[0] = 8'h80; imem[1] = 8'hFF; run_phase(20);
    clear_mem(); imem[0] = 8'h3C; imem[1] = 8'h24; imem[2] = 8'h28; imem[3] = 8'h40; run_phase(24);
    clear_mem(); imem[0] = 8'hA0; run_phase(12);
    clear_mem(); imem[0] = 8'hF0; run_phase(12);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 256; i++) begin
        cls = int'($urandom_range(0, TRAP ? 9 : 10));
        imem[i] = 8'((cls << 4) | int'($urandom_range(0, 15)));
      end
      psr_z = 1'($urandom_range(0, 1));
      run_phase(300);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
